// File: rtl/mem_port_sched.sv
// Single-port memory arbiter: loader owns the port after reset, CPU runs after a
// fixed boot window, dump reader takes over on request or halt.
`timescale 1ns/1ps
module mem_port_sched #(
  parameter int ADDR_W      = 32,
  parameter int BOOT_CYCLES = 4,
  parameter int LOAD_WORDS  = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ldr_wr_en,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [31:0]       ldr_wdata,
  input  logic              ldr_done,
  input  logic              dump_req,
  input  logic [ADDR_W-1:0] dump_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wr_en,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_halt,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       cpu_rdata,
  output logic [31:0]       dump_rdata,
  output logic              cpu_rst,
  output logic              cpu_stall,
  output logic [2:0]        state_o,
  output logic [15:0]       load_cnt,
  output logic              err_flag
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_BOOT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DUMP  = 3'd4
  } state_t;

  localparam int                BC_W       = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BC_W-1:0]   BOOT_LAST  = BC_W'(BOOT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LOAD_LIMIT = ADDR_W'(LOAD_WORDS * 4);

  state_t            r_state;
  logic [BC_W-1:0]   r_boot_cnt;
  logic [15:0]       r_load_cnt;
  logic              r_err;

  logic w_ldr_ok;
  logic w_ldr_acc;
  logic w_ldr_rej;

  // Anything at or past the image end is treated as a corrupt loader stream.
  assign w_ldr_ok  = (ldr_addr < LOAD_LIMIT);
  assign w_ldr_acc = ldr_wr_en &  w_ldr_ok;
  assign w_ldr_rej = ldr_wr_en & ~w_ldr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LOAD;
      r_boot_cnt <= '0;
      r_load_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_ldr_acc && (r_load_cnt != 16'hFFFF))
            r_load_cnt <= r_load_cnt + 16'd1;
          if (w_ldr_rej)
            r_err <= 1'b1;
          // A write arriving with done must land before the port is handed over.
          if (ldr_done && !ldr_wr_en) begin
            r_state    <= S_BOOT;
            r_boot_cnt <= '0;
          end
        end
        S_BOOT: begin
          if (r_boot_cnt == BOOT_LAST) begin
            r_state    <= S_RUN;
            r_boot_cnt <= '0;
          end else begin
            r_boot_cnt <= r_boot_cnt + BC_W'(1);
          end
        end
        S_RUN: begin
          if (dump_req || cpu_halt)
            r_state <= S_DRAIN;
        end
        S_DRAIN: r_state <= S_DUMP;
        S_DUMP: begin
          if (!dump_req && !cpu_halt)
            r_state <= S_RUN;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wr_en = 1'b0;
    cpu_rst   = 1'b1;
    cpu_stall = 1'b0;
    case (r_state)
      S_LOAD: begin
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
        mem_wr_en = w_ldr_acc;
      end
      S_BOOT: ;
      S_RUN: begin
        mem_wr_en = cpu_wr_en;
        cpu_rst   = 1'b0;
      end
      // Stall is up but a store already issued by the CPU still commits here.
      S_DRAIN: begin
        mem_wr_en = cpu_wr_en;
        cpu_rst   = 1'b0;
        cpu_stall = 1'b1;
      end
      S_DUMP: begin
        mem_addr  = dump_addr;
        cpu_rst   = 1'b0;
        cpu_stall = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_rdata  = mem_rdata;
  assign dump_rdata = mem_rdata;
  assign state_o    = r_state;
  assign load_cnt   = r_load_cnt;
  assign err_flag   = r_err;

endmodule
